// File: rtl/store_size_ctrl.sv
// -----------------------------------------------------------------------------
// store_size_ctrl
//
// Narrows a 32-bit register value to a word, halfword or byte store into a
// word-addressed data memory. Word stores are written directly; sub-word
// stores read the containing word, merge the selected lane and write it back.
// Illegal requests (misaligned or reserved size) are rejected without touching
// memory.
//
// Parameters:
//   MEM_LATENCY  cycles from mem_addr valid to mem_rdata valid (1..4)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle request pulse, sampled only when idle
//   size       in   00 word, 01 halfword, 10 byte, 11 reserved
//   addr       in   byte address of the store
//   data_in    in   source register value (low bits used for sub-word)
//   mem_rdata  in   data memory read data
//   mem_addr   out  word-aligned store address
//   mem_wdata  out  merged write data
//   mem_we     out  memory write enable
//   busy       out  high whenever a request is in flight
//   done       out  one-cycle completion pulse
//   err        out  one-cycle reject pulse, coincident with done
// -----------------------------------------------------------------------------
module store_size_ctrl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    // Counter only has to reach MEM_LATENCY-1, which is at most 3.
    localparam int                CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [29:0]        addr_q,  addr_d;   // word address
    logic [1:0]         lane_q,  lane_d;   // byte offset within the word
    logic [1:0]         size_q,  size_d;
    logic [15:0]        data_q,  data_d;   // sub-word source bits
    logic [31:0]        wdata_q, wdata_d;  // word to be written
    logic               req_legal;

    // Replace the addressed lane of a memory word with the store data,
    // leaving every other bit untouched.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  sz,
                                               input logic [15:0] d);
        logic [31:0] w;
        w = word;
        if (sz == SZ_HALF)
            w[{lane[1], 4'b0000} +: 16] = d;
        else
            w[{lane, 3'b000} +: 8] = d[7:0];
        return w;
    endfunction

    always_comb begin
        unique case (size)
            SZ_WORD: req_legal = (addr[1:0] == 2'b00);
            SZ_HALF: req_legal = ~addr[0];
            SZ_BYTE: req_legal = 1'b1;
            default: req_legal = 1'b0;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        data_d  = data_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr[31:2];
                    lane_d  = addr[1:0];
                    size_d  = size;
                    data_d  = data_in[15:0];
                    wdata_d = data_in;   // final value for word stores
                    if (!req_legal)
                        state_d = ERR;
                    else if (size == SZ_WORD)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    wdata_d = merge_lane(mem_rdata, lane_q, size_q, data_q);
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs decode only from registered state, so reset clears mem_we
    // immediately and no input reaches an output combinationally.
    assign busy      = (state_q != IDLE);
    assign mem_we    = (state_q == WRITE);
    assign done      = (state_q == DONE) || (state_q == ERR);
    assign err       = (state_q == ERR);
    assign mem_addr  = ((state_q == READ) || (state_q == WRITE)) ? {addr_q, 2'b00} : '0;
    assign mem_wdata = (state_q == WRITE) ? wdata_q : '0;

endmodule

// File: doc/store_size_ctrl.md
# store_size_ctrl

Store-path companion to the load-side sign/zero extenders: narrows a 32-bit register value to word, halfword or byte and writes it into the word-addressed data memory. Sub-word stores need a read-modify-write of the containing word; this block sequences that RMW with a small FSM. It sits between the multicycle control unit (start/done handshake) and the data memory port.

## Interface
- MEM_LATENCY, 1: cycles from `mem_addr` valid to `mem_rdata` valid; legal range 1–4.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- size  in  2  store size: 00 word, 01 halfword, 10 byte, 11 reserved.
- addr  in  32  byte address of the store.
- data_in  in  32  source register value; the low bits are used for sub-word stores.
- mem_rdata  in  32  data memory read data.
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}, latched at start.
- mem_wdata  out  32  merged write data.
- mem_we  out  1  memory write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when the request was rejected.

## Operation
- Lanes are little-endian:
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword at addr[1]=0 occupies bits [15:0]; at addr[1]=1 it occupies bits [31:16].
- Misalignment rules (each produces an error, no memory access):
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - size=11.
- States:
  - IDLE: all outputs 0.
    - start with a legal sub-word request → READ. addr, size and data_in are latched.
    - start with a legal word request → WRITE.
    - start with an illegal request → ERR.
  - READ: mem_addr is driven and mem_we=0. Stays MEM_LATENCY cycles; an internal counter runs 0..MEM_LATENCY-1. On the last cycle mem_rdata is captured into the merge register → WRITE.
  - WRITE: mem_we=1 for exactly one cycle.
    - Word: mem_wdata = data_in.
    - Sub-word: mem_wdata = captured word with the selected lane replaced by data_in[7:0] or data_in[15:0]. All other bits are preserved unchanged.
    - → DONE.
  - DONE: done=1, err=0 → IDLE.
  - ERR: done=1, err=1, mem_we=0 → IDLE.
- start while busy is ignored and is not queued.
- Changes on addr, size or data_in after the start cycle have no effect; the latched copies are used.
- Reset, including mid-READ or mid-WRITE, returns the FSM to IDLE immediately. mem_we drops asynchronously and the in-flight store is abandoned.

## Timing
- Reset values: mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, err=0; state IDLE; counter 0.
- Cycle numbering: start is sampled at edge 0.
- Word store:
  - WRITE during cycle 1.
  - done during cycle 2.
  - Total latency 2 cycles.
- Sub-word store:
  - READ during cycles 1..MEM_LATENCY.
  - mem_rdata is captured at the edge ending cycle MEM_LATENCY.
  - WRITE during cycle MEM_LATENCY+1.
  - done during cycle MEM_LATENCY+2.
- Error: done=err=1 during cycle 1.
- A new start is accepted in the cycle that done is high only if it is sampled after the return to IDLE. The earliest back-to-back start is therefore the cycle after done.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Reset, then word store: addr=0x100, data_in=0xDEADBEEF, size=00 → mem_we=1 in cycle 1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF; done in cycle 2; err=0.
- Byte store, MEM_LATENCY=1: addr=0x203, data_in=0x123456AB, mem_rdata=0x11223344 → mem_wdata=0xAB223344, mem_addr=0x200, mem_we in cycle 2, done in cycle 3. Repeat for lanes 0–2, expecting 0x112233AB, 0x1122AB44 and 0x11AB3344.
- Halfword store, MEM_LATENCY=3: addr=0x42, data_in=0xFFFF8001, mem_rdata=0xAAAABBBB → mem_wdata=0x8001BBBB; mem_we in cycle 4; done in cycle 5.
- Errors:
  - Halfword at addr=0x41 → done=err=1 in cycle 1; mem_we never asserts.
  - Word at 0x102 → same response.
  - size=11 → same response.
- start pulsed during READ with a different addr → ignored. The original store completes unchanged and the second start produces no done.
- reset asserted during READ of a byte store → busy=0 and mem_we=0 immediately. No write occurs and the next word store completes normally in 2 cycles.
